// File: rtl/pic_acknowledge_sequencer.sv
// pic_acknowledge_sequencer: 8259-style INTA handshake sequencer.
// Raises INT for a pending resolved request and counts INTA pulses.
// It freezes the request path, strobes the in-service/IRR-clear bits,
// drives the vector byte(s), and issues end-of-sequence/AEOI strobes.
// Optional MCS-80 three-pulse mode is enabled by defining PIC_MCS80_MODE_EN.
module pic_acknowledge_sequencer (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       interrupt_acknowledge_n,
    input  logic [7:0] highest_request,
    input  logic [7:0] vector_high,
    input  logic [2:0] vector_low,
    input  logic       auto_eoi_config,
    input  logic       u8086_or_mcs80_config,
    output logic       interrupt_to_cpu,
    output logic       freeze,
    output logic       latch_in_service,
    output logic [7:0] acknowledge_interrupt,
    output logic [7:0] clear_interrupt_request,
    output logic       end_of_acknowledge_sequence,
    output logic [7:0] end_of_interrupt,
    output logic [7:0] out_data,
    output logic       out_enable
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LVL_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2
`ifdef PIC_MCS80_MODE_EN
        ,
        ST_ACK3 = 2'd3
`endif
    } state_e;

    state_e state_q, state_d;

    logic              inta_q;
    logic              int_q,  int_d;
    logic              frz_q,  frz_d;
    logic              lis_q,  lis_d;
    logic [BYTE_W-1:0] ack_q,  ack_d;
    logic [BYTE_W-1:0] clr_q,  clr_d;
    logic              eoas_q, eoas_d;
    logic [BYTE_W-1:0] eoi_q,  eoi_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              oe_q,   oe_d;

    logic              fall_c;
    logic              rise_c;
    logic              mcs80_c;
    logic [LVL_W-1:0]  lvl_c;

    assign fall_c = ~interrupt_acknowledge_n &  inta_q;
    assign rise_c =  interrupt_acknowledge_n & ~inta_q;

`ifdef PIC_MCS80_MODE_EN
    assign mcs80_c = ~u8086_or_mcs80_config;
`else
    logic unused_cfg;
    assign mcs80_c    = 1'b0;
    assign unused_cfg = ^{vector_low, u8086_or_mcs80_config, vector_high[2:0]};
`endif

    // Binary level of the captured one-hot request; spurious maps to level 7
    always_comb begin
        lvl_c = '0;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            if (ack_q[i]) lvl_c = lvl_c | LVL_W'(i);
        end
        if (ack_q == '0) lvl_c = LVL_W'(7);
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state: advance on INTA edges
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fall_c) state_d = ST_ACK1;
            ST_ACK1: if (fall_c) state_d = ST_ACK2;
            ST_ACK2: begin
`ifdef PIC_MCS80_MODE_EN
                if (mcs80_c) begin
                    if (fall_c) state_d = ST_ACK3;
                end else if (rise_c) begin
                    state_d = ST_IDLE;
                end
`else
                if (rise_c) state_d = ST_IDLE;
`endif
            end
`ifdef PIC_MCS80_MODE_EN
            ST_ACK3: if (rise_c) state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values: strobes default low, levels hold
    always_comb begin
        int_d  = int_q;
        frz_d  = frz_q;
        lis_d  = 1'b0;
        ack_d  = ack_q;
        clr_d  = '0;
        eoas_d = 1'b0;
        eoi_d  = '0;
        data_d = data_q;
        oe_d   = oe_q;
        case (state_q)
            ST_IDLE: begin
                int_d = |highest_request;
                if (fall_c) begin
                    int_d = 1'b0;
                    frz_d = 1'b1;
                    ack_d = highest_request;
                    lis_d = |highest_request;
                    clr_d = highest_request;
                    if (mcs80_c) begin
                        oe_d   = 1'b1;
                        data_d = 8'hCD;
                    end
                end
            end
            ST_ACK1: begin
                if (rise_c) oe_d = 1'b0;
                if (fall_c) begin
                    oe_d = 1'b1;
`ifdef PIC_MCS80_MODE_EN
                    data_d = mcs80_c ? {vector_low, lvl_c, 2'b00}
                                     : {vector_high[7:3], lvl_c};
`else
                    data_d = {vector_high[7:3], lvl_c};
`endif
                end
            end
            ST_ACK2: begin
`ifdef PIC_MCS80_MODE_EN
                if (mcs80_c) begin
                    if (rise_c) oe_d = 1'b0;
                    if (fall_c) begin
                        oe_d   = 1'b1;
                        data_d = vector_high;
                    end
                end else if (rise_c) begin
                    oe_d   = 1'b0;
                    frz_d  = 1'b0;
                    eoas_d = 1'b1;
                    eoi_d  = auto_eoi_config ? ack_q : '0;
                end
`else
                if (rise_c) begin
                    oe_d   = 1'b0;
                    frz_d  = 1'b0;
                    eoas_d = 1'b1;
                    eoi_d  = auto_eoi_config ? ack_q : '0;
                end
`endif
            end
`ifdef PIC_MCS80_MODE_EN
            ST_ACK3: begin
                if (rise_c) begin
                    oe_d   = 1'b0;
                    frz_d  = 1'b0;
                    eoas_d = 1'b1;
                    eoi_d  = auto_eoi_config ? ack_q : '0;
                end
            end
`endif
            default: ;
        endcase
    end

    // Output and INTA-history registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inta_q <= 1'b1;
            int_q  <= 1'b0;
            frz_q  <= 1'b0;
            lis_q  <= 1'b0;
            ack_q  <= '0;
            clr_q  <= '0;
            eoas_q <= 1'b0;
            eoi_q  <= '0;
            data_q <= '0;
            oe_q   <= 1'b0;
        end else begin
            inta_q <= interrupt_acknowledge_n;
            int_q  <= int_d;
            frz_q  <= frz_d;
            lis_q  <= lis_d;
            ack_q  <= ack_d;
            clr_q  <= clr_d;
            eoas_q <= eoas_d;
            eoi_q  <= eoi_d;
            data_q <= data_d;
            oe_q   <= oe_d;
        end
    end

    assign interrupt_to_cpu            = int_q;
    assign freeze                      = frz_q;
    assign latch_in_service            = lis_q;
    assign acknowledge_interrupt       = ack_q;
    assign clear_interrupt_request     = clr_q;
    assign end_of_acknowledge_sequence = eoas_q;
    assign end_of_interrupt            = eoi_q;
    assign out_data                    = data_q;
    assign out_enable                  = oe_q;

endmodule

// File: tb/tb_pic_acknowledge_sequencer.sv
// Scoreboard bench for pic_acknowledge_sequencer (directed INTA sequences).
module tb_pic_acknowledge_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       inta_n;
    logic [7:0] hr;
    logic [7:0] vh;
    logic [2:0] vl;
    logic       aeoi;
    logic       cfg8086;
    logic       int_o, frz, lis, eoas, oe;
    logic [7:0] ack, clr, eoi, data;

    always #5 clock = ~clock;

    pic_acknowledge_sequencer dut (
        .clock                       (clock),
        .reset_n                     (reset_n),
        .interrupt_acknowledge_n     (inta_n),
        .highest_request             (hr),
        .vector_high                 (vh),
        .vector_low                  (vl),
        .auto_eoi_config             (aeoi),
        .u8086_or_mcs80_config       (cfg8086),
        .interrupt_to_cpu            (int_o),
        .freeze                      (frz),
        .latch_in_service            (lis),
        .acknowledge_interrupt       (ack),
        .clear_interrupt_request     (clr),
        .end_of_acknowledge_sequence (eoas),
        .end_of_interrupt            (eoi),
        .out_data                    (data),
        .out_enable                  (oe)
    );

    typedef struct packed {
        logic       int_o;
        logic       frz;
        logic       lis;
        logic [7:0] ack;
        logic [7:0] clr;
        logic       eoas;
        logic [7:0] eoi;
        logic       oe;
        logic [7:0] data;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    ev_num = 0;
    logic  frz_p;
    logic  oe_p;

    function automatic snap_t mk(input logic i, input logic f, input logic l,
                                 input logic [7:0] a, input logic [7:0] c,
                                 input logic e, input logic [7:0] ei,
                                 input logic o, input logic [7:0] d);
        snap_t s;
        s.int_o = i; s.frz = f; s.lis = l; s.ack = a; s.clr = c;
        s.eoas = e; s.eoi = ei; s.oe = o; s.data = o ? d : 8'h00;
        return s;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic pulse(input int lo, input int hi);
        inta_n = 1'b0;
        repeat (lo) @(negedge clock);
        inta_n = 1'b1;
        repeat (hi) @(negedge clock);
    endtask

    // Monitor: every output event is matched against the expected queue
    initial begin
        snap_t act, e;
        logic  ev;
        frz_p = 1'b0;
        oe_p  = 1'b0;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1) begin
                ev = lis | (|clr) | eoas | (|eoi) | (oe & ~oe_p) | (frz != frz_p);
                if (ev) begin
                    ev_num++;
                    act = mk(int_o, frz, lis, ack, clr, eoas, eoi, oe, data);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event%0d act=%h exp=none", ev_num, act);
                    end else begin
                        e = exp_q.pop_front();
                        if (act !== e) begin
                            errors++;
                            $display("FAIL event%0d act=%h exp=%h", ev_num, act, e);
                        end
                    end
                end
            end
            frz_p = frz;
            oe_p  = oe;
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; inta_n = 1'b1; hr = 8'h00; vh = 8'h00; vl = 3'b000;
        aeoi = 1'b0; cfg8086 = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_int",  {7'd0, int_o}, 8'h00);
        chk("rst_frz",  {7'd0, frz},   8'h00);
        chk("rst_lis",  {7'd0, lis},   8'h00);
        chk("rst_ack",  ack,           8'h00);
        chk("rst_clr",  clr,           8'h00);
        chk("rst_eoas", {7'd0, eoas},  8'h00);
        chk("rst_eoi",  eoi,           8'h00);
        chk("rst_data", data,          8'h00);
        chk("rst_oe",   {7'd0, oe},    8'h00);

        // 8086, AEOI off, minimum pulse widths; INT rise/fall timing
        vh = 8'h40; hr = 8'h08;
        @(negedge clock);
        chk("int_rise", {7'd0, int_o}, 8'h01);
        hr = 8'h00;
        @(negedge clock);
        chk("int_fall", {7'd0, int_o}, 8'h00);
        hr = 8'h08;
        @(negedge clock);
        exp_q.push_back(mk(0, 1, 1, 8'h08, 8'h08, 0, 8'h00, 0, 8'h00));
        exp_q.push_back(mk(0, 1, 0, 8'h08, 8'h00, 0, 8'h00, 1, 8'h43));
        exp_q.push_back(mk(0, 0, 0, 8'h08, 8'h00, 1, 8'h00, 0, 8'h00));
        pulse(1, 1);
        hr = 8'h00;
        pulse(1, 1);
        repeat (2) @(negedge clock);
        chk("int_after_seq", {7'd0, int_o}, 8'h00);

        // 8086, AEOI on, long pulses, request changes mid-sequence
        aeoi = 1'b1; hr = 8'h08;
        @(negedge clock);
        chk("int_aeoi", {7'd0, int_o}, 8'h01);
        exp_q.push_back(mk(0, 1, 1, 8'h08, 8'h08, 0, 8'h00, 0, 8'h00));
        exp_q.push_back(mk(0, 1, 0, 8'h08, 8'h00, 0, 8'h00, 1, 8'h43));
        exp_q.push_back(mk(0, 0, 0, 8'h08, 8'h00, 1, 8'h08, 0, 8'h00));
        pulse(2, 3);
        hr = 8'h20;
        pulse(3, 1);
        hr = 8'h00;
        repeat (3) @(negedge clock);
        chk("ack_hold", ack, 8'h08);

        // Spurious: request withdrawn at the first INTA, AEOI on
        hr = 8'h08;
        @(negedge clock);
        exp_q.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00));
        exp_q.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h47));
        exp_q.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 8'h00));
        hr = 8'h00;
        pulse(1, 1);
        pulse(1, 1);
        repeat (2) @(negedge clock);

        // Reset during ACK2 while data is driven
        aeoi = 1'b0; hr = 8'h08;
        @(negedge clock);
        exp_q.push_back(mk(0, 1, 1, 8'h08, 8'h08, 0, 8'h00, 0, 8'h00));
        exp_q.push_back(mk(0, 1, 0, 8'h08, 8'h00, 0, 8'h00, 1, 8'h43));
        pulse(1, 1);
        inta_n = 1'b0;
        @(negedge clock);
        chk("mid_oe_before", {7'd0, oe}, 8'h01);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_oe",   {7'd0, oe},   8'h00);
        chk("mid_data", data,         8'h00);
        chk("mid_frz",  {7'd0, frz},  8'h00);
        chk("mid_ack",  ack,          8'h00);
        chk("mid_int",  {7'd0, int_o}, 8'h00);
        inta_n = 1'b1; hr = 8'h00;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        chk("post_rst_eoas", {7'd0, eoas}, 8'h00);

`ifdef PIC_MCS80_MODE_EN
        // MCS-80 three-pulse sequence, level 2
        cfg8086 = 1'b0; aeoi = 1'b1; vl = 3'b101; vh = 8'h12; hr = 8'h04;
        @(negedge clock);
        exp_q.push_back(mk(0, 1, 1, 8'h04, 8'h04, 0, 8'h00, 1, 8'hCD));
        exp_q.push_back(mk(0, 1, 0, 8'h04, 8'h00, 0, 8'h00, 1, 8'hA8));
        exp_q.push_back(mk(0, 1, 0, 8'h04, 8'h00, 0, 8'h00, 1, 8'h12));
        exp_q.push_back(mk(0, 0, 0, 8'h04, 8'h00, 1, 8'h04, 0, 8'h00));
        pulse(1, 1);
        pulse(1, 1);
        hr = 8'h00;
        pulse(1, 1);
        repeat (2) @(negedge clock);
        cfg8086 = 1'b1;
`endif

        repeat (2) @(negedge clock);
        chk("pending_expected", 8'(exp_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pic_acknowledge_sequencer.md
# pic_acknowledge_sequencer

Sequences the 8259-compatible interrupt acknowledge handshake between the priority resolver and the CPU. Raises INT when a resolved request is pending, counts INTA pulses, freezes the request path, latches the in-service bit, and drives the vector byte(s) onto the internal data bus. On sequence completion it issues the end-of-sequence pulse used for auto-rotate and the automatic EOI. It sits between the priority resolver / control-word registers and the data bus buffer.

## Interface
- No parameters.
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- interrupt_acknowledge_n  in  1  INTA from CPU, already synchronised to clock, active low
- highest_request  in  8  one-hot highest-priority unmasked request from the resolver; 0 = none
- vector_high  in  8  ICW2 byte (T7–T3 in 8086 mode, A15–A8 in MCS-80 mode)
- vector_low  in  3  ICW1 A7–A5 (MCS-80 only)
- auto_eoi_config  in  1  ICW4 AEOI
- u8086_or_mcs80_config  in  1  1 = 8086, 0 = MCS-80 (ignored unless PIC_MCS80_MODE_EN)
- interrupt_to_cpu  out  1  INT pin
- freeze  out  1  holds IRR sampling and resolver output during the sequence
- latch_in_service  out  1  one-cycle strobe: set ISR bit `acknowledge_interrupt`
- acknowledge_interrupt  out  8  one-hot level being acknowledged; 0 = spurious
- clear_interrupt_request  out  8  one-cycle strobe clearing the IRR edge latch
- end_of_acknowledge_sequence  out  1  one-cycle strobe at the end of the sequence
- end_of_interrupt  out  8  one-cycle AEOI strobe that clears the ISR bit
- out_data  out  8  vector/opcode byte
- out_enable  out  1  out_data valid; drive the bus

## Operation
- All outputs are registered. Reset value is 0 for every output.
- INTA falling edge occurs at a clock edge where `interrupt_acknowledge_n` = 0 and its registered copy = 1. INTA rising edge is the converse. Reset loads the copy with 1.
- States:
  - IDLE: `interrupt_to_cpu` <= |`highest_request`.
  - IDLE, falling edge → ACK1:
    - `freeze`=1 and `interrupt_to_cpu`=0.
    - `acknowledge_interrupt` <= `highest_request`.
    - Non-zero level: `latch_in_service` and `clear_interrupt_request` pulse that level for one cycle.
    - Zero level (spurious): no strobes; the vector uses level 7.
  - ACK1, falling edge → ACK2. Drive `out_data` = {`vector_high`[7:3], level[2:0]}. Hold `out_enable`=1 while INTA is low.
  - ACK2, rising edge → IDLE:
    - `out_enable`=0 and `freeze`=0.
    - `end_of_acknowledge_sequence` pulses.
    - If `auto_eoi_config`=1 and the level is non-zero, `end_of_interrupt` pulses `acknowledge_interrupt`.
    - `acknowledge_interrupt` holds until the next ACK1.
- The ACK1 pulse drives no data in 8086 mode.
- Any falling edge in ACK2 (a second INTA while the data is still pending) is ignored.
- A change in `highest_request` during ACK1/ACK2 is ignored; the captured level stays.
- `reset_n` asserted mid-sequence → immediate IDLE, all outputs 0, no end-of-sequence or EOI strobes.

## Timing
- INT asserts 1 cycle after `highest_request` becomes non-zero in IDLE. It deasserts 1 cycle after `highest_request` returns to 0 in IDLE.
- Strobes are exactly one cycle wide and are registered at the detecting edge.
- `out_enable` rises at the edge detecting the data-pulse falling edge. It falls at the edge detecting that pulse's rising edge.
- Minimum sequence: ACK1 low 1 cycle, high 1 cycle, ACK2 low 1 cycle; there is no upper bound on duration.

## Configuration
- PIC_MCS80_MODE_EN defined:
  - With `u8086_or_mcs80_config`=0, the sequencer runs a three-pulse sequence IDLE→ACK1→ACK2→ACK3→IDLE.
  - ACK1 drives 0xCD (CALL); ACK2 drives {`vector_low`, level[2:0], 2'b00} (interval 4); ACK3 drives `vector_high`.
  - Strobes move to the ACK3 rising edge. `latch_in_service` stays at ACK1.
- PIC_MCS80_MODE_EN undefined: `u8086_or_mcs80_config` and `vector_low` are unused, there is no ACK3 state, and the sequencer runs 8086 mode only.

## Test plan
- Reset sequence: release reset with `highest_request`=0 → all outputs 0 and state IDLE.
- Normal 8086 sequence, AEOI off: `highest_request`=8'h08 and `vector_high`=8'h40 → INT=1 next cycle.
  - First INTA: `latch_in_service` and `clear_interrupt_request`=8'h08 pulse once, `freeze`=1, INT=0.
  - Second INTA: `out_data`=8'h43 with `out_enable`=1.
  - Rising edge: `end_of_acknowledge_sequence` pulses, `freeze`=0, `end_of_interrupt`=0.
- Normal 8086 sequence, AEOI on: same stimulus with `auto_eoi_config`=1 → `end_of_interrupt`=8'h08 for 1 cycle at the second INTA rising edge.
- Spurious: request withdrawn before INTA (`highest_request`=0 at ACK1) → no strobes; `out_data`=8'h47 for `vector_high`=8'h40.
- Reset mid-sequence: assert `reset_n` low during ACK2 with `out_enable`=1 → outputs 0 immediately; no `end_of_acknowledge_sequence` after release.
- MCS-80 sequence (macro defined), level 2, `vector_low`=3'b101, `vector_high`=8'h12 → bytes 8'hCD, 8'hA8, 8'h12; end strobe after the third INTA.
